// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory target with valid/ready channels and programmable latency
// Serves one load/store at a time; bad addresses return rsp_err with no array side effects.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0] w_word;
  logic [AW-1:0] w_idx;
  logic        w_err;
  logic        w_access;
  logic        w_commit;
  logic [31:0] w_rdata;

  // Word index is formed in full 32-bit unsigned arithmetic so it can never wrap into range.
  assign w_word   = (r_addr - BASE_ADDR) >> 2;
  assign w_idx    = w_word[AW-1:0];
  assign w_err    = (r_addr[1:0] != 2'b00) | (r_addr < BASE_ADDR) | (w_word >= DEPTH_WORDS);
  assign w_rdata  = r_mem[w_idx];

  // The access happens on the first edge spent in RESP, before rsp_valid rises.
  assign w_access = (r_state == S_RESP) & ~r_rsp_valid;
  assign w_commit = w_access & r_we & ~w_err;

  assign req_ready = (r_state == S_IDLE) & ~reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_cnt   <= LAT4;
            r_state <= (LATENCY == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err | r_we) ? 32'd0 : w_rdata;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder (LATENCY=2 and LATENCY=0 instances)
// Index 0 is the LATENCY=2/BASE=0/DEPTH=256 instance, index 1 the LATENCY=0/BASE=0x100/DEPTH=16 one.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;

  mem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h100), .LATENCY(0)) dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!reset && rsp_valid[0] && rsp_ready[0]) begin
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp0_unexpected: got rdata %h err %b with empty queue", rsp_rdata[0], rsp_err[0]);
      end else begin
        e = q0.pop_front();
        check("rsp0_rdata", rsp_rdata[0], e.rdata);
        check("rsp0_err", {31'd0, rsp_err[0]}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!reset && rsp_valid[1] && rsp_ready[1]) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp1_unexpected: got rdata %h err %b with empty queue", rsp_rdata[1], rsp_err[1]);
      end else begin
        e = q1.pop_front();
        check("rsp1_rdata", rsp_rdata[1], e.rdata);
        check("rsp1_err", {31'd0, rsp_err[1]}, {31'd0, e.err});
      end
    end
  end

  task automatic push_exp(input int d, input logic [31:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic drive_req(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
  endtask

  // Full transaction: accept, measure accept-to-valid latency, wait for the handshake.
  task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_lat);
    int n;
    push_exp(d, exp_rd, exp_err);
    @(posedge clk); #1;
    drive_req(d, we, addr, wdata, be);
    n = 0;
    @(negedge clk);
    while (!req_ready[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept", {31'd0, req_ready[d]}, 32'd1);
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, exp_lat);
    n = 0;
    while (rsp_valid[d] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("rsp_drop", {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  initial begin : stim
    logic [5:0] rdy_pat;
    logic [5:0] vld_pat;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      req_be[d]    = 4'd0;
      rsp_ready[d] = 1'b1;
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata[0], 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, req_ready[0]}, 32'd1);

    // Store, then partial-byte stores, then loads
    issue(0, 1'b1, 32'h8,  32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
    issue(0, 1'b0, 32'h8,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 3);
    issue(0, 1'b1, 32'h8,  32'h000000AA, 4'b0001, 32'h0, 1'b0, 3);
    issue(0, 1'b0, 32'h8,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 3);
    issue(0, 1'b1, 32'h8,  32'h11223344, 4'b1010, 32'h0, 1'b0, 3);
    issue(0, 1'b0, 32'h8,  32'h0,        4'h0, 32'h11AD33AA, 1'b0, 3);
    issue(0, 1'b1, 32'h8,  32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 3);
    issue(0, 1'b0, 32'h8,  32'h0,        4'h0, 32'h11AD33AA, 1'b0, 3);

    // Errors: misaligned and out-of-range loads and stores leave the array alone
    issue(0, 1'b0, 32'h6,   32'h0,        4'h0, 32'h0, 1'b1, 3);
    issue(0, 1'b0, 32'h400, 32'h0,        4'h0, 32'h0, 1'b1, 3);
    issue(0, 1'b1, 32'h9,   32'h55555555, 4'hF, 32'h0, 1'b1, 3);
    issue(0, 1'b0, 32'h8,   32'h0,        4'h0, 32'h11AD33AA, 1'b0, 3);
    issue(0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0, 3);
    issue(0, 1'b0, 32'h3FC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 3);

    // Reset in the middle of WAIT for a store: the store is dropped
    issue(0, 1'b1, 32'h10, 32'h12345678, 4'hF, 32'h0, 1'b0, 3);
    @(posedge clk); #1;
    drive_req(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    check("t1_accept", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t1_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t1_rel_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("t1_rel_ready", {31'd0, req_ready[0]}, 32'd1);
    repeat (4) @(negedge clk);
    check("t1_no_rsp", {31'd0, rsp_valid[0]}, 32'd0);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'h12345678, 1'b0, 3);

    // Back-pressure: response held stable, req_valid pulses ignored
    rsp_ready[0] = 1'b0;
    push_exp(0, 32'h11AD33AA, 1'b0);
    @(posedge clk); #1;
    drive_req(0, 1'b0, 32'h8, 32'h0, 4'h0);
    @(negedge clk);
    check("t5_accept", {31'd0, req_ready[0]}, 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      drive_req(0, 1'b1, 32'h8, 32'h0, 4'hF);
      req_valid[0] = k[0];
      @(negedge clk);
      check("t5_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("t5_rdata", rsp_rdata[0], 32'h11AD33AA);
      check("t5_err", {31'd0, rsp_err[0]}, 32'd0);
      check("t5_ready", {31'd0, req_ready[0]}, 32'd0);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t5_done", {31'd0, rsp_valid[0]}, 32'd0);
    issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h11AD33AA, 1'b0, 3);

    // LATENCY=0 instance with BASE_ADDR=0x100, DEPTH_WORDS=16
    issue(1, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1);
    issue(1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 1);
    issue(1, 1'b0, 32'hFC,  32'h0,        4'h0, 32'h0, 1'b1, 1);
    issue(1, 1'b0, 32'h140, 32'h0,        4'h0, 32'h0, 1'b1, 1);
    issue(1, 1'b1, 32'h13C, 32'h01020304, 4'hF, 32'h0, 1'b0, 1);
    issue(1, 1'b0, 32'h13C, 32'h0,        4'h0, 32'h01020304, 1'b0, 1);

    // Back-to-back loads with req_valid held high
    rdy_pat = 6'b001001;
    vld_pat = 6'b100100;
    push_exp(1, 32'hCAFEF00D, 1'b0);
    push_exp(1, 32'hCAFEF00D, 1'b0);
    drive_req(1, 1'b0, 32'h100, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("b2b_ready", {31'd0, req_ready[1]}, {31'd0, rdy_pat[k]});
      check("b2b_valid", {31'd0, rsp_valid[1]}, {31'd0, vld_pat[k]});
    end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;

    repeat (4) @(negedge clk);
    check("q0_empty", q0.size(), 32'd0);
    check("q1_empty", q1.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
